cell_plot_writer: RTL and testbench

//   Consumer end of the life-simulation changed-cell stream. Accepts (x, y, alive) cell updates

---
 rtl/cell_plot_writer.sv | 177 +++++++++++++++++
 tb/tb_cell_plot_writer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_plot_writer.sv
// Buffers (x, y, alive) cell updates in a FIFO and expands each into CELL_SIZE x CELL_SIZE pixel writes.
// Optional build macro CLEAR_ON_RESET_EN: paint every pixel DEAD_COLOUR after reset before drawing cells.
module cell_plot_writer #(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned CELL_SIZE    = 1,
    parameter logic [2:0]  ALIVE_COLOUR = 3'b111,
    parameter logic [2:0]  DEAD_COLOUR  = 3'b000,
    parameter int unsigned SCR_W        = 160,
    parameter int unsigned SCR_H        = 120
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_x,
    input  logic [6:0] in_y,
    input  logic       in_alive,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic [7:0] drop_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SHIFT = (CELL_SIZE == 4) ? 2 : (CELL_SIZE == 2) ? 1 : 0;
    localparam logic [2:0]  CS_LAST = 3'(CELL_SIZE - 1);

`ifdef CLEAR_ON_RESET_EN
    typedef enum logic [1:0] {S_IDLE, S_PLOT, S_CLEAR} state_t;
    localparam state_t RESET_STATE = S_CLEAR;
`else
    typedef enum logic [1:0] {S_IDLE, S_PLOT} state_t;
    localparam state_t RESET_STATE = S_IDLE;
`endif

    state_t state, state_next;

    logic [15:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop, load, drop;

    logic [15:0] head;
    logic [10:0] hpx, hpy;
    logic        in_range;

    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] col;
    logic [2:0] dx, dy;

`ifdef CLEAR_ON_RESET_EN
    logic [7:0] cx;
    logic [6:0] cy;
`endif

    assign in_ready = (count != CNT_W'(FIFO_DEPTH));
    assign push     = in_valid & in_ready;
    assign busy     = (count != '0) || (state != S_IDLE);

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {in_x, in_y, in_alive};
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Bounds are checked on 11-bit scaled coordinates so large in_x/in_y cannot wrap into range.
    assign head     = mem[rd_ptr];
    assign hpx      = 11'(head[15:8]) << SHIFT;
    assign hpy      = 11'(head[7:1]) << SHIFT;
    assign in_range = ((hpx + 11'(CELL_SIZE)) <= 11'(SCR_W)) &&
                      ((hpy + 11'(CELL_SIZE)) <= 11'(SCR_H));

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        drop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop = 1'b1;
                    if (in_range) begin
                        load       = 1'b1;
                        state_next = S_PLOT;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            S_PLOT: begin
                if (dx == CS_LAST && dy == CS_LAST) state_next = S_IDLE;
            end
`ifdef CLEAR_ON_RESET_EN
            S_CLEAR: begin
                if (cx == 8'(SCR_W - 1) && cy == 7'(SCR_H - 1)) state_next = S_IDLE;
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= RESET_STATE;
            px         <= '0;
            py         <= '0;
            col        <= '0;
            dx         <= '0;
            dy         <= '0;
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            plot       <= 1'b0;
            drop_count <= '0;
`ifdef CLEAR_ON_RESET_EN
            cx         <= '0;
            cy         <= '0;
`endif
        end else begin
            state <= state_next;
            plot  <= 1'b0;
            if (load) begin
                px  <= hpx[7:0];
                py  <= hpy[6:0];
                col <= head[0] ? ALIVE_COLOUR : DEAD_COLOUR;
                dx  <= '0;
                dy  <= '0;
            end
            if (drop && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
            if (state == S_PLOT) begin
                plot   <= 1'b1;
                x      <= px + {5'b0, dx};
                y      <= py + {4'b0, dy};
                colour <= col;
                if (dx == CS_LAST) begin
                    dx <= '0;
                    dy <= dy + 1'b1;
                end else begin
                    dx <= dx + 1'b1;
                end
            end
`ifdef CLEAR_ON_RESET_EN
            if (state == S_CLEAR) begin
                plot   <= 1'b1;
                x      <= cx;
                y      <= cy;
                colour <= DEAD_COLOUR;
                if (cx == 8'(SCR_W - 1)) begin
                    cx <= '0;
                    cy <= cy + 1'b1;
                end else begin
                    cx <= cx + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_cell_plot_writer.sv
// Directed bench for cell_plot_writer: one DUT at CELL_SIZE=1 and one at CELL_SIZE=2.
// With CLEAR_ON_RESET_EN defined it also checks the post-reset screen clear.
module tb_cell_plot_writer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_n;
    logic       v1, v2;
    logic [7:0] ix;
    logic [6:0] iy;
    logic       ia;

    logic       r1, r2, p1, p2, b1, b2;
    logic [7:0] x1, x2, d1, d2;
    logic [6:0] y1, y2;
    logic [2:0] c1, c2;

    int checks = 0;
    int errors = 0;

    logic [17:0] log1 [$];
    int          plots2 = 0;

`ifdef CLEAR_ON_RESET_EN
    localparam logic BUSY_AFTER_RESET = 1'b1;
`else
    localparam logic BUSY_AFTER_RESET = 1'b0;
`endif

    cell_plot_writer #(
        .FIFO_DEPTH(16), .CELL_SIZE(1), .ALIVE_COLOUR(3'b111), .DEAD_COLOUR(3'b000),
        .SCR_W(160), .SCR_H(120)
    ) dut1 (
        .clock(clock), .reset_n(reset_n), .in_valid(v1), .in_ready(r1),
        .in_x(ix), .in_y(iy), .in_alive(ia), .x(x1), .y(y1), .colour(c1),
        .plot(p1), .busy(b1), .drop_count(d1)
    );

    cell_plot_writer #(
        .FIFO_DEPTH(16), .CELL_SIZE(2), .ALIVE_COLOUR(3'b111), .DEAD_COLOUR(3'b000),
        .SCR_W(160), .SCR_H(120)
    ) dut2 (
        .clock(clock), .reset_n(reset_n), .in_valid(v2), .in_ready(r2),
        .in_x(ix), .in_y(iy), .in_alive(ia), .x(x2), .y(y2), .colour(c2),
        .plot(p2), .busy(b2), .drop_count(d2)
    );

    always @(negedge clock) begin
        if (p1 === 1'b1) log1.push_back({x1, y1, c1});
        if (p2 === 1'b1) plots2 = plots2 + 1;
    end

    task automatic push1(input logic [7:0] px, input logic [6:0] py, input logic pa);
        @(negedge clock);
        v1 = 1'b1; ix = px; iy = py; ia = pa;
        @(posedge clock);
    endtask

    task automatic push2(input logic [7:0] px, input logic [6:0] py, input logic pa);
        @(negedge clock);
        v2 = 1'b1; ix = px; iy = py; ia = pa;
        @(posedge clock);
    endtask

    task automatic settle();
`ifdef CLEAR_ON_RESET_EN
        int n = 0;
        while ((b1 !== 1'b0 || b2 !== 1'b0) && n < 20000) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 20000) begin
            errors++;
            $display("FAIL settle_timeout busy1=%b busy2=%b want 0 0", b1, b2);
        end
`endif
    endtask

    task automatic test_reset();
        reset_n = 1'b0; v1 = 1'b0; v2 = 1'b0; ix = '0; iy = '0; ia = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++; if (p1 !== 1'b0)   begin errors++; $display("FAIL reset_plot got %b want 0", p1); end
        checks++; if (x1 !== 8'd0)   begin errors++; $display("FAIL reset_x got %0d want 0", x1); end
        checks++; if (y1 !== 7'd0)   begin errors++; $display("FAIL reset_y got %0d want 0", y1); end
        checks++; if (c1 !== 3'd0)   begin errors++; $display("FAIL reset_colour got %0d want 0", c1); end
        checks++; if (d1 !== 8'd0)   begin errors++; $display("FAIL reset_drop got %0d want 0", d1); end
        checks++; if (b1 !== BUSY_AFTER_RESET) begin errors++; $display("FAIL reset_busy got %b want %b", b1, BUSY_AFTER_RESET); end
        checks++; if (p2 !== 1'b0)   begin errors++; $display("FAIL reset_plot2 got %b want 0", p2); end
        reset_n = 1'b1;
        @(negedge clock);
        checks++; if (r1 !== 1'b1)   begin errors++; $display("FAIL reset_ready got %b want 1", r1); end
        settle();
    endtask

    task automatic test_single();
        log1.delete();
        push1(8'd10, 7'd20, 1'b1);
        @(negedge clock); v1 = 1'b0;
        checks++; if (p1 !== 1'b0) begin errors++; $display("FAIL single_lat0 plot got %b want 0", p1); end
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", b1); end
        @(negedge clock);
        checks++; if (p1 !== 1'b0) begin errors++; $display("FAIL single_lat1 plot got %b want 0", p1); end
        @(negedge clock);
        checks++; if (p1 !== 1'b1) begin errors++; $display("FAIL single_plot got %b want 1", p1); end
        checks++; if ({x1, y1, c1} !== {8'd10, 7'd20, 3'd7})
            begin errors++; $display("FAIL single_pixel got (%0d,%0d,%0d) want (10,20,7)", x1, y1, c1); end
        @(negedge clock);
        checks++; if (p1 !== 1'b0) begin errors++; $display("FAIL single_after plot got %b want 0", p1); end
        repeat (5) @(negedge clock);
        #1;
        checks++; if (log1.size() != 1) begin errors++; $display("FAIL single_count got %0d want 1", log1.size()); end
    endtask

    task automatic test_cell2();
        logic [7:0] ex [4] = '{8'd6, 8'd7, 8'd6, 8'd7};
        logic [6:0] ey [4] = '{7'd8, 7'd8, 7'd9, 7'd9};
        push2(8'd3, 7'd4, 1'b0);
        @(negedge clock); v2 = 1'b0;
        @(negedge clock);
        checks++; if (p2 !== 1'b0) begin errors++; $display("FAIL cell2_lat plot got %b want 0", p2); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++;
            if ({p2, x2, y2, c2} !== {1'b1, ex[i], ey[i], 3'd0}) begin
                errors++;
                $display("FAIL cell2_px%0d got plot=%b (%0d,%0d,%0d) want plot=1 (%0d,%0d,0)",
                         i, p2, x2, y2, c2, ex[i], ey[i]);
            end
        end
        @(negedge clock);
        checks++; if (p2 !== 1'b0) begin errors++; $display("FAIL cell2_end plot got %b want 0", p2); end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        int cyc = 0;
        int first_stall = -1;
        int n = 0;
        logic rdy;
        log1.delete();
        while (k < 40 && cyc < 1000) begin
            @(negedge clock);
            v1 = 1'b1; ix = 8'(k + 1); iy = 7'(40 - k); ia = k[0];
            rdy = r1;
            if (!rdy && first_stall < 0) first_stall = k;
            @(posedge clock);
            if (rdy) k++;
            cyc++;
        end
        @(negedge clock); v1 = 1'b0;
        checks++; if (cyc >= 1000) begin errors++; $display("FAIL b2b_push_timeout got %0d pushed want 40", k); end
        checks++; if (first_stall != 31) begin errors++; $display("FAIL b2b_first_stall got %0d want 31", first_stall); end
        while (b1 !== 1'b0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        checks++; if (n >= 300) begin errors++; $display("FAIL b2b_drain_timeout busy got %b want 0", b1); end
        repeat (3) @(negedge clock);
        #1;
        checks++; if (log1.size() != 40) begin errors++; $display("FAIL b2b_count got %0d want 40", log1.size()); end
        for (int i = 0; i < 40 && i < log1.size(); i++) begin
            checks++;
            if (log1[i] !== {8'(i + 1), 7'(40 - i), ((i % 2) == 1) ? 3'd7 : 3'd0}) begin
                errors++;
                $display("FAIL b2b_entry%0d got %h want %h", i, log1[i],
                         {8'(i + 1), 7'(40 - i), ((i % 2) == 1) ? 3'd7 : 3'd0});
            end
        end
        checks++; if ({p1, b1} !== 2'b00) begin errors++; $display("FAIL b2b_idle got plot=%b busy=%b want 0 0", p1, b1); end
    endtask

    task automatic test_drop();
        int before2;
        log1.delete();
        push1(8'd160, 7'd5, 1'b1);
        push1(8'd5, 7'd120, 1'b1);
        @(negedge clock); v1 = 1'b0;
        repeat (6) @(negedge clock);
        #1;
        checks++; if (log1.size() != 0) begin errors++; $display("FAIL drop_noplot got %0d plots want 0", log1.size()); end
        checks++; if (d1 !== 8'd2) begin errors++; $display("FAIL drop_two got %0d want 2", d1); end
        push1(8'd159, 7'd119, 1'b1);
        @(negedge clock); v1 = 1'b0;
        repeat (5) @(negedge clock);
        #1;
        checks++;
        if (log1.size() != 1 || log1[0] !== {8'd159, 7'd119, 3'd7}) begin
            errors++;
            $display("FAIL drop_corner got %0d plots first=%h want 1 plot %h", log1.size(),
                     (log1.size() > 0) ? log1[0] : 18'h0, {8'd159, 7'd119, 3'd7});
        end
        checks++; if (d1 !== 8'd2) begin errors++; $display("FAIL drop_corner_cnt got %0d want 2", d1); end
        before2 = plots2;
        push2(8'd80, 7'd0, 1'b1);
        push2(8'd79, 7'd59, 1'b1);
        @(negedge clock); v2 = 1'b0;
        repeat (10) @(negedge clock);
        #1;
        checks++; if (d2 !== 8'd1) begin errors++; $display("FAIL drop_cs2 got %0d want 1", d2); end
        checks++; if (plots2 - before2 != 4) begin errors++; $display("FAIL drop_cs2_plots got %0d want 4", plots2 - before2); end
        for (int i = 0; i < 300; i++) push1(8'd255, 7'd0, 1'b0);
        @(negedge clock); v1 = 1'b0;
        repeat (5) @(negedge clock);
        checks++; if (d1 !== 8'd255) begin errors++; $display("FAIL drop_saturate got %0d want 255", d1); end
    endtask

    task automatic test_reset_mid();
        int l1, l2;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            v1 = 1'b1; v2 = 1'b1; ix = 8'(i + 1); iy = 7'(i + 1); ia = 1'b1;
            @(posedge clock);
        end
        @(negedge clock);
        v1 = 1'b0; v2 = 1'b0; reset_n = 1'b0;
        @(negedge clock);
        checks++; if ({p1, p2} !== 2'b00) begin errors++; $display("FAIL mid_plot got %b%b want 00", p1, p2); end
        checks++; if ({b1, b2} !== {2{BUSY_AFTER_RESET}}) begin errors++; $display("FAIL mid_busy got %b%b want %b%b", b1, b2, BUSY_AFTER_RESET, BUSY_AFTER_RESET); end
        checks++; if ({r1, r2} !== 2'b11) begin errors++; $display("FAIL mid_ready got %b%b want 11", r1, r2); end
        checks++; if ({d1, d2} !== 16'h0) begin errors++; $display("FAIL mid_drop got %0d %0d want 0 0", d1, d2); end
        reset_n = 1'b1;
        #1;
        l1 = log1.size();
        l2 = plots2;
`ifndef CLEAR_ON_RESET_EN
        repeat (30) @(negedge clock);
        #1;
        checks++; if (log1.size() != l1) begin errors++; $display("FAIL mid_stale1 got %0d plots want 0", log1.size() - l1); end
        checks++; if (plots2 != l2) begin errors++; $display("FAIL mid_stale2 got %0d plots want 0", plots2 - l2); end
`endif
        settle();
    endtask

`ifdef CLEAR_ON_RESET_EN
    task automatic test_clear();
        int n = 0;
        log1.delete();
        @(negedge clock); reset_n = 1'b0;
        @(negedge clock); reset_n = 1'b1;
        v1 = 1'b1; ix = 8'd7; iy = 7'd9; ia = 1'b1;
        checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL clear_ready got %b want 1", r1); end
        @(posedge clock);
        @(negedge clock); v1 = 1'b0;
        while (b1 !== 1'b0 && n < 20000) begin
            @(negedge clock);
            n++;
        end
        checks++; if (n >= 20000) begin errors++; $display("FAIL clear_timeout busy got %b want 0", b1); end
        repeat (3) @(negedge clock);
        #1;
        checks++; if (log1.size() != 19201) begin errors++; $display("FAIL clear_count got %0d want 19201", log1.size()); end
        if (log1.size() == 19201) begin
            checks++; if (log1[0] !== 18'h0) begin errors++; $display("FAIL clear_first got %h want 0", log1[0]); end
            checks++; if (log1[19199] !== {8'd159, 7'd119, 3'd0}) begin errors++; $display("FAIL clear_last got %h want %h", log1[19199], {8'd159, 7'd119, 3'd0}); end
            checks++; if (log1[19200] !== {8'd7, 7'd9, 3'd7}) begin errors++; $display("FAIL clear_queued got %h want %h", log1[19200], {8'd7, 7'd9, 3'd7}); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_cell2();
        test_back_to_back();
        test_drop();
        test_reset_mid();
`ifdef CLEAR_ON_RESET_EN
        test_clear();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
